// File: rtl/seq_right_shifter.sv
// Multi-cycle right shifter. It captures an operand, a shift magnitude and a
// fill mode on a start request, then shifts right one bit per clock. The
// result register updates only on the edge that raises the done strobe.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; Op holds the last completed result
// ST_SHIFT | shifting the work register one bit per edge, cnt counts down
// ST_DONE  | result just written to Op; done high for this one cycle
module seq_right_shifter #(
  parameter int WIDTH = 16,
  parameter int MAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             arith,
  input  logic [WIDTH-1:0] Ip,
  input  logic [MAG_W-1:0] shift_mag,
  output logic [WIDTH-1:0] Op,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] wreg_q, wreg_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [MAG_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] shifted;

  // One-bit right shift of the work register; arithmetic mode replicates the MSB.
  always_comb begin
    shifted = {mode_q & wreg_q[WIDTH-1], wreg_q[WIDTH-1:1]};
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    wreg_d  = wreg_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    op_d    = op_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          wreg_d = Ip;
          cnt_d  = shift_mag;
          mode_d = arith;
          if (shift_mag == '0) begin
            // A zero shift completes immediately with the operand as the result.
            op_d    = Ip;
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        wreg_d = shifted;
        cnt_d  = cnt_q - MAG_W'(1);
        if (cnt_q == MAG_W'(1)) begin
          op_d    = shifted;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // busy and done are registered from the next state so they line up
    // with the state register without any combinational output decode.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wreg_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      op_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wreg_q  <= wreg_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Op   = op_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_seq_right_shifter.sv
// Bench for seq_right_shifter: directed vector table, hand-written corner
// sequences, and random operations checked against an arithmetic model.
module tb_seq_right_shifter;

  logic        clk;
  logic        rst;
  logic        start;
  logic        arith;
  logic [15:0] Ip;
  logic [3:0]  shift_mag;
  logic [15:0] Op;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  logic [15:0] prev_op;

  seq_right_shifter dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .arith     (arith),
    .Ip        (Ip),
    .shift_mag (shift_mag),
    .Op        (Op),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ip;
    logic [3:0]  mag;
    logic        ar;
    logic [15:0] exp_op;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain shift operators on the operand as a number.
  function automatic logic [15:0] ref_shift(input logic [15:0] ip, input logic [3:0] mag,
                                            input logic ar);
    logic signed [15:0] s;
    s = ip;
    if (ar) return 16'(s >>> mag);
    return ip >> mag;
  endfunction

  // Called just after a negedge. Issues one operation, checks latency,
  // busy during the operation, Op stability, result, and the drop of
  // done/busy. Returns at the negedge after the DONE->IDLE edge, so a
  // following call starts at the earliest legal edge.
  task automatic do_op(input string name, input logic [15:0] ip, input logic [3:0] mag,
                       input logic ar, input logic [15:0] exp_op);
    int lat;
    Ip = ip; shift_mag = mag; arith = ar; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    Ip = 16'($urandom); shift_mag = 4'($urandom); arith = 1'($urandom);
    lat = 0;
    forever begin
      @(negedge clk);
      if (done || lat >= 40) break;
      check({name, " busy_mid"}, {31'd0, busy}, 32'd1);
      check({name, " op_hold"}, {16'd0, Op}, {16'd0, prev_op});
      lat++;
    end
    check({name, " latency"}, lat, {28'd0, mag});
    check({name, " busy_at_done"}, {31'd0, busy}, 32'd1);
    check({name, " op"}, {16'd0, Op}, {16'd0, exp_op});
    prev_op = exp_op;
    @(negedge clk);
    check({name, " done_drop"}, {31'd0, done}, 32'd0);
    check({name, " busy_drop"}, {31'd0, busy}, 32'd0);
    check({name, " op_after"}, {16'd0, Op}, {16'd0, exp_op});
  endtask

  vec_t vecs[8];

  initial begin
    int lat;
    logic [15:0] rip;
    logic [3:0]  rmag;
    logic        rar;

    vecs[0] = '{16'h8000, 4'd15, 1'b0, 16'h0001};
    vecs[1] = '{16'h8000, 4'd4,  1'b1, 16'hF800};
    vecs[2] = '{16'h8000, 4'd4,  1'b0, 16'h0800};
    vecs[3] = '{16'h1234, 4'd0,  1'b0, 16'h1234};
    vecs[4] = '{16'h8000, 4'd15, 1'b1, 16'hFFFF};
    vecs[5] = '{16'h7FFF, 4'd15, 1'b1, 16'h0000};
    vecs[6] = '{16'hA5A5, 4'd1,  1'b1, 16'hD2D2};
    vecs[7] = '{16'hF00F, 4'd0,  1'b1, 16'hF00F};

    rst = 1'b1; start = 1'b0; arith = 1'b0; Ip = '0; shift_mag = '0;
    prev_op = 16'h0000;
    #12;
    check("reset Op", {16'd0, Op}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle busy", {31'd0, busy}, 32'd0);

    // Directed table, back-to-back at the earliest legal start each time.
    for (int i = 0; i < 8; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].ip, vecs[i].mag, vecs[i].ar, vecs[i].exp_op);
    end

    // Back-to-back pair.
    do_op("b2b_a", 16'h0003, 4'd1,  1'b0, 16'h0001);
    do_op("b2b_b", 16'h8001, 4'd15, 1'b1, 16'hFFFF);

    // Busy ignore: start held high with other operands through SHIFT and DONE.
    Ip = 16'h00F0; shift_mag = 4'd4; arith = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    Ip = 16'hFFFF; shift_mag = 4'd1; arith = 1'b1; start = 1'b1;
    lat = 0;
    forever begin
      @(negedge clk);
      if (done || lat >= 40) break;
      lat++;
    end
    check("ignore latency", lat, 32'd4);
    check("ignore op", {16'd0, Op}, 32'h000F);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("ignore busy_drop", {31'd0, busy}, 32'd0);
    lat = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) lat++;
    end
    check("ignore no_second_op", lat, 32'd0);
    check("ignore op_kept", {16'd0, Op}, 32'h000F);
    prev_op = 16'h000F;

    // Reset in the middle of a shift.
    Ip = 16'hFFFF; shift_mag = 4'd8; arith = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("midrst busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst Op", {16'd0, Op}, 32'd0);
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) lat++;
    end
    check("midrst no_done", lat, 32'd0);
    prev_op = 16'h0000;
    do_op("post_rst", 16'h0003, 4'd1, 1'b0, 16'h0001);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      rip  = 16'($urandom);
      rmag = 4'($urandom_range(0, 15));
      rar  = 1'($urandom);
      do_op($sformatf("rand%0d", i), rip, rmag, rar, ref_shift(rip, rmag, rar));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
